// File: rtl/mult_sequencer.sv
// Sequencer for the 12-bit serial unsigned multiplier: X in, Y in, multiply, product out.
// Each stage is started with a one-cycle pulse and ends on a rising edge of that unit's finish flag.
module mult_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       fx,
    input  logic       fy,
    input  logic       fm,
    input  logic       fo,
    output logic       sx,
    output logic       sy,
    output logic       sm,
    output logic       so,
    output logic       sel_y,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] stage
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHX   = 3'd1,
        S_SHY   = 3'd2,
        S_MUL   = 3'd3,
        S_SHO   = 3'd4,
        S_FIN   = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t          r_state, w_next;
    logic            r_prev, r_edge;
    logic [TO_W-1:0] r_cnt;
    logic            r_sx, r_sy, r_sm, r_so, r_sel_y, r_busy, r_done, r_err;
    logic            w_flag, w_in_stage, w_to, w_entry;

    always_comb begin
        w_flag = 1'b0;
        case (r_state)
            S_SHX:   w_flag = fx;
            S_SHY:   w_flag = fy;
            S_MUL:   w_flag = fm;
            S_SHO:   w_flag = fo;
            default: w_flag = 1'b0;
        endcase
    end

    assign w_in_stage = (r_state == S_SHX) || (r_state == S_SHY) ||
                        (r_state == S_MUL) || (r_state == S_SHO);
    assign w_to       = (r_cnt == TO_W'(TIMEOUT - 1));

    // A registered finish edge seen in the same cycle as the timeout still advances.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_next = S_SHX;
            S_SHX:   if (r_edge)      w_next = S_SHY;
                     else if (w_to)   w_next = S_ERROR;
            S_SHY:   if (r_edge)      w_next = S_MUL;
                     else if (w_to)   w_next = S_ERROR;
            S_MUL:   if (r_edge)      w_next = S_SHO;
                     else if (w_to)   w_next = S_ERROR;
            S_SHO:   if (r_edge)      w_next = S_FIN;
                     else if (w_to)   w_next = S_ERROR;
            S_FIN:                    w_next = S_IDLE;
            S_ERROR: if (start)       w_next = S_SHX;
            default:                  w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    assign w_entry = (w_next != r_state);

    // r_prev is forced high on entry so a flag still high from the previous run cannot count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_edge <= 1'b0;
            r_cnt  <= '0;
        end else if (w_entry) begin
            r_prev <= 1'b1;
            r_edge <= 1'b0;
            r_cnt  <= '0;
        end else if (w_in_stage) begin
            r_prev <= w_flag;
            r_edge <= ~r_prev & w_flag;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_sm    <= 1'b0;
            r_so    <= 1'b0;
            r_sel_y <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sx    <= (w_next == S_SHX) && (r_state != S_SHX);
            r_sy    <= (w_next == S_SHY) && (r_state != S_SHY);
            r_sm    <= (w_next == S_MUL) && (r_state != S_MUL);
            r_so    <= (w_next == S_SHO) && (r_state != S_SHO);
            r_sel_y <= (w_next == S_SHY) || (w_next == S_MUL) || (w_next == S_SHO);
            r_busy  <= (w_next != S_IDLE) && (w_next != S_ERROR);
            r_done  <= (w_next == S_FIN);
            if (w_next == S_ERROR)
                r_err <= 1'b1;
            else if ((w_next == S_SHX) && ((r_state == S_IDLE) || (r_state == S_ERROR)))
                r_err <= 1'b0;
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign sm    = r_sm;
    assign so    = r_so;
    assign sel_y = r_sel_y;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign stage = r_state;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: expected behaviour per run is derived from the stage timeline
// (entry edge of each stage = previous entry + flag delay + 1) and compared every cycle.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, abort, fx, fy, fm, fo;
    logic       sx, sy, sm, so, sel_y, busy, done, err;
    logic [2:0] stage;
    int         checks = 0;
    int         errors = 0;

    mult_sequencer #(.TIMEOUT(64), .TO_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .fx(fx), .fy(fy), .fm(fm), .fo(fo),
        .sx(sx), .sy(sy), .sm(sm), .so(so),
        .sel_y(sel_y), .busy(busy), .done(done), .err(err), .stage(stage)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] obs_vec();
        return {stage, sx, sy, sm, so, sel_y, busy, done, err};
    endfunction

    function automatic logic [10:0] mk(input int st, input logic [3:0] p);
        logic [2:0] s3;
        s3 = 3'(st);
        return {s3, p, (st >= 2 && st <= 4), (st >= 1 && st <= 5), (st == 5), (st == 6)};
    endfunction

    // d[s] = edges after stage entry at which flag s is first sampled high (>=64: never).
    task automatic run_seq(input int d0, input int d1, input int d2, input int d3,
                           input int stale_lo, input int abort_at, input int restart_at,
                           input string tag);
        int d[4];
        int ent[5];
        int errat, last, st, ndone;
        logic [3:0] p;
        bit f[4];
        d     = '{d0, d1, d2, d3};
        ent   = '{0, 1 << 30, 1 << 30, 1 << 30, 1 << 30};
        errat = -1;
        for (int s = 0; s < 4; s++) begin
            if (d[s] >= 64) begin
                errat = ent[s] + 64;
                break;
            end
            ent[s+1] = ent[s] + d[s] + 1;
        end
        last = (errat >= 0) ? errat + 1 : ent[4] + 1;
        if (abort_at >= 0) last = abort_at + 1;

        f = '{stale_lo >= 0, 1'b0, 1'b0, 1'b0};
        fx = f[0]; fy = f[1]; fm = f[2]; fo = f[3];
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int t = 0; t <= last; t++) begin
            if (abort_at >= 0 && t >= abort_at)  st = 0;
            else if (errat >= 0 && t >= errat)   st = 6;
            else if (t > ent[4])                 st = 0;
            else if (t == ent[4])                st = 5;
            else begin
                st = 1;
                for (int s = 1; s < 4; s++) if (t >= ent[s]) st = s + 1;
            end
            for (int s = 0; s < 4; s++) p[3-s] = (st == s + 1) && (t == ent[s]);
            chk($sformatf("%s t=%0d", tag, t), 32'(obs_vec()), 32'(mk(st, p)));
            ndone += int'(done);
            start = (t + 1 == restart_at);
            abort = (t + 1 == abort_at);
            if (t == stale_lo) f[0] = 1'b0;
            for (int s = 0; s < 4; s++)
                if (d[s] < 64 && ent[s] < (1 << 30) && t == ent[s] + d[s] - 1) f[s] = 1'b1;
            fx = f[0]; fy = f[1]; fm = f[2]; fo = f[3];
            if (t < last) tick();
        end
        start = 1'b0;
        abort = 1'b0;
        chk($sformatf("%s done_count", tag), 32'(ndone), (errat < 0 && abort_at < 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        fx = 1'b0; fy = 1'b0; fm = 1'b0; fo = 1'b0;
        #12;
        chk("reset_state", 32'(obs_vec()), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 32'(obs_vec()), 32'd0);

        run_seq(13, 13, 13, 13, -1, -1, -1, "normal");
        run_seq(12, 9, 7, 5, 5, -1, -1, "stale_fx");
        run_seq(13, 13, 99, 13, -1, -1, -1, "timeout_mul");
        run_seq(13, 13, 13, 13, -1, -1, -1, "start_from_error");
        run_seq(63, 2, 63, 2, -1, -1, -1, "edge_at_limit");
        run_seq(2, 64, 5, 5, -1, -1, -1, "timeout_shy");

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_error", 32'({stage, busy, err}), 32'({3'd0, 1'b0, 1'b1}));
        tick();
        chk("err_sticky_idle", 32'({stage, busy, err}), 32'({3'd0, 1'b0, 1'b1}));

        run_seq(13, 13, 13, 13, -1, 20, -1, "abort_shy");
        run_seq(13, 13, 13, 13, -1, -1, -1, "after_abort");
        run_seq(13, 13, 13, 13, -1, -1, 3, "restart_ignored");

        repeat (6) begin
            run_seq(int'($urandom_range(2, 40)), int'($urandom_range(2, 40)),
                    int'($urandom_range(2, 40)), int'($urandom_range(2, 40)),
                    -1, -1, -1, "random");
        end

        // Drive into MUL, then hit the async reset between clock edges.
        fx = 1'b0; fy = 1'b0; fm = 1'b0; fo = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        fx = 1'b1;
        tick();
        tick();
        tick();
        fy = 1'b1;
        tick();
        tick();
        chk("reached_mul", 32'(stage), 32'd3);
        #3 reset = 1'b1;
        #1 chk("async_reset_mid_mul", 32'(obs_vec()), 32'd0);
        start = 1'b1;
        tick();
        tick();
        chk("start_during_reset", 32'(obs_vec()), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_after_release", 32'(obs_vec()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
